// File: rtl/asu_ddr5_dqs_pkg.sv
// Shared definitions for the DDR5 DQS sequencing stage.
//   dqs_state_t   : sequencer states (idle, preamble, data, interamble, postamble)
//   DQS_TOGGLE    : DQS pair driven during the data window
//   DQS_LOW       : DQS pair driven during postamble and idle
//   PRE_LEN_MAX   : longest preamble in cycles
//   POST_LEN_MAX  : longest postamble in cycles
//   GAP_MAX_DEF   : default largest gap bridged with interamble
//   clamp_pre_len : maps the raw preamble length onto 1..PRE_LEN_MAX
package asu_ddr5_dqs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_INTERAMBLE,
    ST_POSTAMBLE
  } dqs_state_t;

  localparam logic [1:0] DQS_TOGGLE = 2'b10;
  localparam logic [1:0] DQS_LOW    = 2'b00;

  localparam int PRE_LEN_MAX  = 4;
  localparam int POST_LEN_MAX = 2;
  localparam int GAP_MAX_DEF  = 6;

  // A zero length still needs one preamble cycle; anything longer than the
  // maximum is treated as the maximum.
  function automatic logic [2:0] clamp_pre_len(input logic [2:0] len);
    if (len == 3'd0) begin
      return 3'd1;
    end else if (len > 3'(PRE_LEN_MAX)) begin
      return 3'(PRE_LEN_MAX);
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/asu_ddr5_wr_en_delay.sv
// Write-enable delay line for the DQS sequencer.
// The total write-enable to data-window latency is DLY cycles: DLY-1 stages
// live here and the last stage is the sequencer's own output register.
//   clk_i     : system clock
//   rst_i     : synchronous active-high reset, clears the whole line
//   wr_en_i   : per-cycle write enable
//   window_o  : data window active in the next cycle
//   look_o[k] : data window active k cycles after the next cycle
module asu_ddr5_wr_en_delay #(
  parameter int DLY = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           wr_en_i,
  output logic           window_o,
  output logic [DLY-2:1] look_o
);

  // sr_q[0] holds the newest sample; sr_q[DLY-2] is the oldest.
  logic [DLY-2:0] sr_q;
  logic [DLY-2:0] sr_d;

  always_comb begin
    sr_d = {sr_q[DLY-3:0], wr_en_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign window_o = sr_q[DLY-2];

  // Younger stages describe windows further into the future.
  always_comb begin
    look_o = '0;
    for (int k = 1; k <= DLY - 2; k++) begin
      look_o[k] = sr_q[DLY-2-k];
    end
  end

endmodule

// File: rtl/asu_ddr5_dqs_fsm.sv
// DQS sequencing stage of the DDR5 PHY write path.
// Delays the write-enable window by DLY cycles and drives the DQS pattern
// (preamble, toggling strobe, interamble, postamble) with its output enable.
// DLY must be at least GAP_MAX+2 and GAP_MAX at least 6.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   wr_en_i             : write enable, high for each data cycle
//   pre_len_i           : preamble length 1..4 (0 -> 1, >4 -> 4)
//   post_len_i          : postamble length, 0 -> 1 cycle, 1 -> 2 cycles
//   preamble_bits_i     : preamble DQS pair from the shift block
//   interamble_bits_i   : interamble DQS pair from the shift block
//   dqs_o               : DQS pair {first half, second half}
//   dqs_oe_o            : DQS driver enable
//   data_valid_o        : data window active
//   preamble_valid_o    : request for the next preamble pair
//   interamble_valid_o  : interamble window active
module asu_ddr5_dqs_fsm
  import asu_ddr5_dqs_pkg::*;
#(
  parameter int DLY     = 8,
  parameter int GAP_MAX = GAP_MAX_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_en_i,
  input  logic [2:0] pre_len_i,
  input  logic       post_len_i,
  input  logic [1:0] preamble_bits_i,
  input  logic [1:0] interamble_bits_i,
  output logic [1:0] dqs_o,
  output logic       dqs_oe_o,
  output logic       data_valid_o,
  output logic       preamble_valid_o,
  output logic       interamble_valid_o
);

  logic           window;
  logic [DLY-2:1] look;

  dqs_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       dqs_oe_q, dqs_oe_d;
  logic       data_valid_q, data_valid_d;
  logic       pre_valid_q, pre_valid_d;
  logic       inter_valid_q, inter_valid_d;

  logic [2:0] pre_len;
  logic [2:0] post_cnt;
  logic       pre_hit;
  logic       pv_hit;
  logic       close_hit;
  logic       gap_hit;
  logic [2:0] gap_cnt;

  asu_ddr5_wr_en_delay #(
    .DLY(DLY)
  ) u_wr_en_delay (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en_i  (wr_en_i),
    .window_o (window),
    .look_o   (look)
  );

  assign pre_len  = clamp_pre_len(pre_len_i);
  assign post_cnt = post_len_i ? 3'(POST_LEN_MAX - 1) : 3'd0;

  // Lookahead decode. Tap look[k] says a window starts k cycles after the
  // next one. pre_hit: a preamble must begin next cycle. pv_hit: it begins
  // the cycle after. close_hit: a window lies inside the preamble distance.
  // gap_cnt is the nearest window's distance minus one, used as the
  // interamble length.
  always_comb begin
    pre_hit   = 1'b0;
    pv_hit    = 1'b0;
    close_hit = window;
    gap_hit   = 1'b0;
    gap_cnt   = 3'd0;
    for (int k = 1; k <= PRE_LEN_MAX; k++) begin
      if (pre_len == 3'(k)) begin
        pre_hit = look[k];
        pv_hit  = look[k+1];
      end
    end
    for (int k = 1; k < PRE_LEN_MAX; k++) begin
      if (3'(k) < pre_len) begin
        close_hit = close_hit | look[k];
      end
    end
    for (int k = GAP_MAX; k >= 1; k--) begin
      if (look[k]) begin
        gap_hit = 1'b1;
        gap_cnt = 3'(k - 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 3'd0;
      dqs_oe_q      <= 1'b0;
      data_valid_q  <= 1'b0;
      pre_valid_q   <= 1'b0;
      inter_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dqs_oe_q      <= dqs_oe_d;
      data_valid_q  <= data_valid_d;
      pre_valid_q   <= pre_valid_d;
      inter_valid_q <= inter_valid_d;
    end
  end

  // cnt_q counts the cycles still to follow the current one in a preamble,
  // interamble or postamble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (window) begin
          state_d = ST_DATA;
        end else if (pre_hit) begin
          state_d = ST_PREAMBLE;
          cnt_d   = pre_len - 3'd1;
        end
      end
      ST_PREAMBLE: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (window) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!window) begin
          if (gap_hit) begin
            state_d = ST_INTERAMBLE;
            cnt_d   = gap_cnt;
          end else begin
            state_d = ST_POSTAMBLE;
            cnt_d   = post_cnt;
          end
        end
      end
      ST_INTERAMBLE: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (window) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_POSTAMBLE;
          cnt_d   = post_cnt;
        end
      end
      ST_POSTAMBLE: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (pre_hit) begin
          state_d = ST_PREAMBLE;
          cnt_d   = pre_len - 3'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Registered outputs follow the next state. preamble_valid runs one cycle
  // ahead of the preamble: it is set whenever the cycle after the next one
  // will be a preamble cycle.
  always_comb begin
    dqs_oe_d      = (state_d != ST_IDLE);
    data_valid_d  = (state_d == ST_DATA);
    inter_valid_d = (state_d == ST_INTERAMBLE);
    pre_valid_d   = ((state_d == ST_PREAMBLE) && (cnt_d != 3'd0)) ||
                    ((state_d == ST_IDLE) && pv_hit) ||
                    ((state_d == ST_POSTAMBLE) && (cnt_d == 3'd0) && pv_hit);
  end

  // Preamble and interamble pairs pass straight through from the shift block.
  always_comb begin
    case (state_q)
      ST_PREAMBLE:   dqs_o = preamble_bits_i;
      ST_INTERAMBLE: dqs_o = interamble_bits_i;
      ST_DATA:       dqs_o = DQS_TOGGLE;
      default:       dqs_o = DQS_LOW;
    endcase
  end

  assign dqs_oe_o           = dqs_oe_q;
  assign data_valid_o       = data_valid_q;
  assign preamble_valid_o   = pre_valid_q;
  assign interamble_valid_o = inter_valid_q;

  // A gap longer than GAP_MAX always leaves room for postamble plus preamble,
  // so leaving postamble must never find a window inside the preamble reach.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_q == ST_POSTAMBLE) && (state_d != ST_POSTAMBLE)) begin
      assert (!close_hit);
    end
  end

endmodule

// File: tb/tb_asu_ddr5_dqs_fsm.sv
// Self-checking bench for asu_ddr5_dqs_fsm with DLY = 8, GAP_MAX = 6.
// Each scenario describes, per cycle after reset release, the write-enable
// plan and the hand-derived expected phase and preamble_valid; every cycle
// the packed output vector {dqs_oe, data_valid, preamble_valid,
// interamble_valid, dqs[1:0]} is compared against that expectation.
module tb_asu_ddr5_dqs_fsm;

  localparam int NCYC     = 64;
  localparam int PH_IDLE  = 0;
  localparam int PH_PRE   = 1;
  localparam int PH_DATA  = 2;
  localparam int PH_INTER = 3;
  localparam int PH_POST  = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       wr_en_i;
  logic [2:0] pre_len_i;
  logic       post_len_i;
  logic [1:0] preamble_bits_i;
  logic [1:0] interamble_bits_i;
  logic [1:0] dqs_o;
  logic       dqs_oe_o;
  logic       data_valid_o;
  logic       preamble_valid_o;
  logic       interamble_valid_o;

  int checkCount = 0;
  int failCount  = 0;

  int expPhase [NCYC];
  bit expPv    [NCYC];
  bit wrPlan   [NCYC];
  int rstCycle;

  always #5 clk_i = ~clk_i;

  asu_ddr5_dqs_fsm #(
    .DLY     (8),
    .GAP_MAX (6)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .wr_en_i            (wr_en_i),
    .pre_len_i          (pre_len_i),
    .post_len_i         (post_len_i),
    .preamble_bits_i    (preamble_bits_i),
    .interamble_bits_i  (interamble_bits_i),
    .dqs_o              (dqs_o),
    .dqs_oe_o           (dqs_oe_o),
    .data_valid_o       (data_valid_o),
    .preamble_valid_o   (preamble_valid_o),
    .interamble_valid_o (interamble_valid_o)
  );

  // Count one comparison and report it when the DUT disagrees.
  task automatic checkOutput(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Wipe the per-cycle plan before describing a new scenario.
  task automatic clearPlan();
    for (int i = 0; i < NCYC; i++) begin
      expPhase[i] = PH_IDLE;
      expPv[i]    = 1'b0;
      wrPlan[i]   = 1'b0;
    end
    rstCycle = -1;
  endtask

  task automatic markPhase(input int ph, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) expPhase[i] = ph;
  endtask

  task automatic markPv(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) expPv[i] = 1'b1;
  endtask

  task automatic markWr(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) wrPlan[i] = 1'b1;
  endtask

  // Reset the DUT, check the reset state, then play the plan cycle by cycle.
  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge.
  task automatic applyStimulus(input string name, input logic [2:0] preLen, input logic postLen);
    logic [5:0] expVec;
    logic [1:0] expDqs;
    int         ph;
    rst_i             = 1'b1;
    wr_en_i           = 1'b0;
    pre_len_i         = preLen;
    post_len_i        = postLen;
    preamble_bits_i   = 2'b11;
    interamble_bits_i = 2'b01;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput({name, "/reset"},
                {dqs_oe_o, data_valid_o, preamble_valid_o, interamble_valid_o, dqs_o}, 6'b000000);
    rst_i = 1'b0;
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk_i);
      #1;
      wr_en_i           = wrPlan[k];
      rst_i             = (k == rstCycle);
      preamble_bits_i   = k[0] ? 2'b01 : 2'b11;
      interamble_bits_i = k[0] ? 2'b11 : 2'b01;
      @(negedge clk_i);
      ph = expPhase[k];
      case (ph)
        PH_PRE:   expDqs = preamble_bits_i;
        PH_INTER: expDqs = interamble_bits_i;
        PH_DATA:  expDqs = 2'b10;
        default:  expDqs = 2'b00;
      endcase
      expVec = {(ph != PH_IDLE), (ph == PH_DATA), expPv[k], (ph == PH_INTER), expDqs};
      checkOutput($sformatf("%s/c%0d", name, k),
                  {dqs_oe_o, data_valid_o, preamble_valid_o, interamble_valid_o, dqs_o}, expVec);
    end
    wr_en_i = 1'b0;
    rst_i   = 1'b0;
  endtask

  initial begin
    // Single burst, preamble 2, postamble 1.
    clearPlan();
    markWr(20, 27);
    markPv(25, 26);
    markPhase(PH_PRE, 26, 27);
    markPhase(PH_DATA, 28, 35);
    markPhase(PH_POST, 36, 36);
    applyStimulus("single", 3'd2, 1'b0);

    // Gap of 2 filled with interamble, no second preamble.
    clearPlan();
    markWr(20, 27);
    markWr(30, 37);
    markPv(25, 26);
    markPhase(PH_PRE, 26, 27);
    markPhase(PH_DATA, 28, 35);
    markPhase(PH_INTER, 36, 37);
    markPhase(PH_DATA, 38, 45);
    markPhase(PH_POST, 46, 46);
    applyStimulus("inter", 3'd2, 1'b0);

    // Back-to-back runs merge into one continuous window.
    clearPlan();
    markWr(20, 27);
    markWr(28, 35);
    markPv(25, 26);
    markPhase(PH_PRE, 26, 27);
    markPhase(PH_DATA, 28, 43);
    markPhase(PH_POST, 44, 44);
    applyStimulus("b2b", 3'd2, 1'b0);

    // Gap of 7: postamble, one idle cycle, fresh preamble.
    clearPlan();
    markWr(20, 27);
    markWr(35, 42);
    markPv(23, 26);
    markPhase(PH_PRE, 24, 27);
    markPhase(PH_DATA, 28, 35);
    markPhase(PH_POST, 36, 37);
    markPv(38, 41);
    markPhase(PH_PRE, 39, 42);
    markPhase(PH_DATA, 43, 50);
    markPhase(PH_POST, 51, 52);
    applyStimulus("gap7", 3'd4, 1'b1);

    // Preamble length 0 behaves as 1.
    clearPlan();
    markWr(20, 27);
    markPv(26, 26);
    markPhase(PH_PRE, 27, 27);
    markPhase(PH_DATA, 28, 35);
    markPhase(PH_POST, 36, 36);
    applyStimulus("pre0", 3'd0, 1'b0);

    // Preamble length 7 behaves as 4.
    clearPlan();
    markWr(20, 27);
    markPv(23, 26);
    markPhase(PH_PRE, 24, 27);
    markPhase(PH_DATA, 28, 35);
    markPhase(PH_POST, 36, 36);
    applyStimulus("pre7", 3'd7, 1'b0);

    // Reset during the data window discards the rest of the burst.
    clearPlan();
    markWr(20, 30);
    rstCycle = 30;
    markPv(25, 26);
    markPhase(PH_PRE, 26, 27);
    markPhase(PH_DATA, 28, 30);
    applyStimulus("rstmid", 3'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
